// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width, sample type and I2S transmit FSM states.
package audio_pkg;

   localparam int unsigned AUDIO_W    = 16;
   localparam int unsigned UNDERRUN_W = 8;

   typedef logic signed [AUDIO_W-1:0] audio_sample_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SHIFT = 2'd2,
      PAD   = 2'd3
   } i2s_tx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous level into the clk domain and flags its edges.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   din          : asynchronous input level
//   rise_c       : one-cycle pulse after a synchronised 0->1 transition
//   fall_c       : one-cycle pulse after a synchronised 1->0 transition
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic rise_c,
   output logic fall_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Synchroniser chain plus one extra stage for edge comparison.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_c =  sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_c = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/i2s_dac_sender.sv
// Serialises mono samples onto the codec DAC port in I2S format, the same
// sample on left and right slots. bclk/daclrck are codec-mastered.
// Ports:
//   clk, reset_n   : system clock, asynchronous active-low reset
//   sample_data    : sample to play, valid/ready handshake with
//   sample_valid   :   sample_ready (combinational; one sample per frame)
//   bclk, daclrck  : codec bit and frame clocks (asynchronous)
//   dacdat         : registered serial data to codec
//   frame_start    : one-cycle pulse at each left-slot start
//   underrun_count : saturating count of frames sent without a fresh sample
module i2s_dac_sender
   import audio_pkg::*;
#(
   parameter int unsigned W           = AUDIO_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [W-1:0]          sample_data,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   input  logic                  bclk,
   input  logic                  daclrck,
   output logic                  dacdat,
   output logic                  frame_start,
   output logic [UNDERRUN_W-1:0] underrun_count
);

   localparam int unsigned CNT_W = $clog2(W + 1);

   logic bclk_fall_c;
   logic bclk_rise_unused;
   logic lr_fall_c;
   logic lr_rise_c;
   logic xfer_c;

   i2s_tx_state_e         state_q, state_d;
   logic [W-1:0]          hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic [W-1:0]          frame_sample_q, frame_sample_d;
   logic [W-1:0]          shreg_q, shreg_d;
   logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
   logic                  dacdat_q, dacdat_d;
   logic                  frame_start_q, frame_start_d;
   logic [UNDERRUN_W-1:0] underrun_q, underrun_d;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (bclk),
      .rise_c  (bclk_rise_unused),
      .fall_c  (bclk_fall_c)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_lr_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (daclrck),
      .rise_c  (lr_rise_c),
      .fall_c  (lr_fall_c)
   );

   // The holding register drains on lr_fall, so it can refill in that same cycle.
   assign sample_ready = !hold_full_q || lr_fall_c;
   assign xfer_c       = sample_valid && sample_ready;

   // Next-state and next-output logic.
   always_comb begin
      state_d        = state_q;
      hold_d         = hold_q;
      hold_full_d    = hold_full_q;
      frame_sample_d = frame_sample_q;
      shreg_d        = shreg_q;
      bitcnt_d       = bitcnt_q;
      dacdat_d       = dacdat_q;
      frame_start_d  = 1'b0;
      underrun_d     = underrun_q;

      // LR edges take priority over a coincident bclk_fall and truncate any slot.
      if (lr_fall_c) begin
         if (hold_full_q) begin
            frame_sample_d = hold_q;
            hold_full_d    = 1'b0;
         end else begin
            frame_sample_d = '0;
            if (underrun_q != '1) begin
               underrun_d = underrun_q + UNDERRUN_W'(1);
            end
         end
         shreg_d       = frame_sample_d;
         frame_start_d = 1'b1;
         dacdat_d      = 1'b0;
         state_d       = ARMED;
      end else if (lr_rise_c && (state_q != IDLE)) begin
         shreg_d  = frame_sample_q;
         dacdat_d = 1'b0;
         state_d  = ARMED;
      end else if (bclk_fall_c) begin
         case (state_q)
            ARMED: begin
               dacdat_d = shreg_q[W-1];
               shreg_d  = {shreg_q[W-2:0], 1'b0};
               bitcnt_d = CNT_W'(1);
               state_d  = SHIFT;
            end
            SHIFT: begin
               if (bitcnt_q == CNT_W'(W)) begin
                  dacdat_d = 1'b0;
                  state_d  = PAD;
               end else begin
                  dacdat_d = shreg_q[W-1];
                  shreg_d  = {shreg_q[W-2:0], 1'b0};
                  bitcnt_d = bitcnt_q + CNT_W'(1);
               end
            end
            default: begin
               dacdat_d = 1'b0;
            end
         endcase
      end

      if (xfer_c) begin
         hold_d      = sample_data;
         hold_full_d = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         hold_q         <= '0;
         hold_full_q    <= 1'b0;
         frame_sample_q <= '0;
         shreg_q        <= '0;
         bitcnt_q       <= '0;
         dacdat_q       <= 1'b0;
         frame_start_q  <= 1'b0;
         underrun_q     <= '0;
      end else begin
         state_q        <= state_d;
         hold_q         <= hold_d;
         hold_full_q    <= hold_full_d;
         frame_sample_q <= frame_sample_d;
         shreg_q        <= shreg_d;
         bitcnt_q       <= bitcnt_d;
         dacdat_q       <= dacdat_d;
         frame_start_q  <= frame_start_d;
         underrun_q     <= underrun_d;
      end
   end

   assign dacdat         = dacdat_q;
   assign frame_start    = frame_start_q;
   assign underrun_count = underrun_q;

endmodule

// File: tb/tb_i2s_dac_sender.sv
// Self-checking bench for i2s_dac_sender: a codec model drives bclk/daclrck
// (6 clk per bclk), captures dacdat on bclk rising edges and compares each
// slot against expectations queued by the test that set up the stimulus.
module tb_i2s_dac_sender;

   localparam int unsigned W = 16;

   typedef struct {
      bit          chk;
      logic [31:0] word;
   } slot_exp_t;

   logic         clk          = 1'b0;
   logic         reset_n      = 1'b0;
   logic [W-1:0] sample_data  = '0;
   logic         sample_valid = 1'b0;
   logic         bclk         = 1'b1;
   logic         daclrck      = 1'b1;
   logic         sample_ready;
   logic         dacdat;
   logic         frame_start;
   logic [7:0]   underrun_count;

   int        compared      = 0;
   int        mismatched    = 0;
   int        fs_cnt        = 0;
   bit        chk_ready_mid = 1'b0;
   slot_exp_t exp_q[$];

   i2s_dac_sender #(.W(W), .SYNC_STAGES(2)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sample_data    (sample_data),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .bclk           (bclk),
      .daclrck        (daclrck),
      .dacdat         (dacdat),
      .frame_start    (frame_start),
      .underrun_count (underrun_count)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         if (frame_start === 1'b1) fs_cnt++;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // First nbits of a slot: one delay bit, the sample MSB-first, then padding.
   function automatic logic [31:0] slot_word(input logic [W-1:0] s, input int nbits);
      logic [31:0] full;
      full = {1'b0, s, 15'b0};
      return full >> (32 - nbits);
   endfunction

   task automatic push_slot(input bit chk, input logic [31:0] w);
      slot_exp_t e;
      e.chk  = chk;
      e.word = w;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input logic [W-1:0] s, input int nbits);
      push_slot(1'b1, slot_word(s, nbits));
      push_slot(1'b1, slot_word(s, nbits));
   endtask

   // Codec model: LR changes with bclk fall, dacdat sampled just before bclk rise.
   task automatic run_frames(input int nframes, input int nbits);
      logic [31:0] w;
      slot_exp_t   e;
      for (int f = 0; f < nframes; f++) begin
         for (int ch = 0; ch < 2; ch++) begin
            w = '0;
            for (int k = 0; k < nbits; k++) begin
               @(negedge clk);
               bclk = 1'b0;
               if (k == 0) daclrck = (ch == 1);
               repeat (3) @(negedge clk);
               w = {w[30:0], dacdat};
               if (chk_ready_mid && ch == 0 && k == nbits / 2) begin
                  compared++;
                  if (sample_ready !== 1'b0) begin
                     mismatched++;
                     $display("FAIL ready_mid_frame f%0d: got %b want 0", f, sample_ready);
                  end
               end
               bclk = 1'b1;
               repeat (2) @(negedge clk);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               if (e.chk) begin
                  compared++;
                  if (w !== e.word) begin
                     mismatched++;
                     $display("FAIL slot f%0d ch%0d: got %h want %h", f, ch, w, e.word);
                  end
               end
            end
         end
      end
   endtask

   task automatic write_sample(input logic [W-1:0] s);
      bit done;
      done = 1'b0;
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = s;
      for (int i = 0; i < 4000 && !done; i++) begin
         #1;
         if (sample_ready === 1'b1) done = 1'b1;
         @(negedge clk);
      end
      sample_valid = 1'b0;
      compared++;
      if (!done) begin
         mismatched++;
         $display("FAIL write_accept %h: got no ready want ready", s);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n      = 1'b0;
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      exp_q.delete();
   endtask

   task automatic check_underrun(input string name, input logic [7:0] want);
      compared++;
      if (underrun_count !== want) begin
         mismatched++;
         $display("FAIL %s: got %0d want %0d", name, underrun_count, want);
      end
   endtask

   task automatic check_fs(input string name, input int got, input int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      compared++;
      if (dacdat !== 1'b0) begin mismatched++; $display("FAIL reset_dacdat: got %b want 0", dacdat); end
      compared++;
      if (sample_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
      compared++;
      if (frame_start !== 1'b0) begin mismatched++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
      check_underrun("reset_underrun", 8'd0);
      do_reset();
   endtask

   task automatic test_single_sample();
      int fs0;
      do_reset();
      fs0 = fs_cnt;
      write_sample(16'hA5C3);
      push_frame(16'hA5C3, 32);
      run_frames(1, 32);
      check_fs("single_frame_start", fs_cnt - fs0, 1);
      check_underrun("single_underrun", 8'd0);
   endtask

   task automatic test_underrun();
      int fs0;
      do_reset();
      fs0 = fs_cnt;
      for (int i = 0; i < 3; i++) push_frame(16'h0000, 32);
      run_frames(3, 32);
      check_underrun("underrun_three", 8'd3);
      check_fs("underrun_frame_start", fs_cnt - fs0, 3);
   endtask

   task automatic test_back_to_back();
      int           acc;
      bit           run;
      logic [W-1:0] cur;
      acc = 0;
      run = 1'b1;
      cur = 16'd1;
      do_reset();
      for (int i = 1; i <= 3; i++) push_frame(W'(i), 32);
      chk_ready_mid = 1'b1;
      fork
         begin
            run_frames(3, 32);
            run = 1'b0;
         end
         begin
            while (run) begin
               @(negedge clk);
               sample_valid = 1'b1;
               sample_data  = cur;
               #1;
               if (sample_ready === 1'b1) begin
                  acc++;
                  cur = cur + W'(1);
               end
            end
            sample_valid = 1'b0;
         end
      join
      chk_ready_mid = 1'b0;
      check_fs("b2b_accept_count", acc, 4);
      check_underrun("b2b_underrun", 8'd0);
   endtask

   task automatic test_fill_on_lr_fall();
      do_reset();
      write_sample(16'h3C5A);
      push_frame(16'h3C5A, 32);
      push_frame(16'h8001, 32);
      fork
         run_frames(2, 32);
         begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 2000 && !seen; i++) begin
               @(negedge clk);
               #1;
               if (sample_ready === 1'b1) begin
                  seen         = 1'b1;
                  sample_valid = 1'b1;
                  sample_data  = 16'h8001;
               end
            end
            @(negedge clk);
            sample_valid = 1'b0;
            #1;
            compared++;
            if (!seen) begin mismatched++; $display("FAIL fill_ready_at_lr_fall: got 0 want 1"); end
            compared++;
            if (sample_ready !== 1'b0) begin
               mismatched++;
               $display("FAIL fill_hold_full_kept: ready got %b want 0", sample_ready);
            end
         end
      join
      check_underrun("fill_underrun", 8'd0);
   endtask

   task automatic test_saturation();
      do_reset();
      run_frames(254, 4);
      check_underrun("sat_254", 8'd254);
      run_frames(3, 4);
      check_underrun("sat_255", 8'd255);
   endtask

   task automatic test_reset_mid_shift();
      do_reset();
      write_sample(16'hFFFF);
      push_slot(1'b0, 32'h0);
      push_slot(1'b1, 32'h0);
      push_frame(16'h1234, 32);
      fork
         run_frames(2, 32);
         begin
            repeat (40) @(negedge clk);
            #1;
            compared++;
            if (dacdat !== 1'b1) begin mismatched++; $display("FAIL mid_dacdat_before: got %b want 1", dacdat); end
            reset_n = 1'b0;
            #1;
            compared++;
            if (dacdat !== 1'b0) begin mismatched++; $display("FAIL mid_dacdat_reset: got %b want 0", dacdat); end
            compared++;
            if (sample_ready !== 1'b1) begin mismatched++; $display("FAIL mid_ready_reset: got %b want 1", sample_ready); end
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            write_sample(16'h1234);
         end
      join
      check_underrun("mid_underrun", 8'd0);
   endtask

   task automatic test_short_slot();
      do_reset();
      write_sample(16'hA5C3);
      push_frame(16'hA5C3, 8);
      run_frames(1, 8);
      write_sample(16'h0F0F);
      push_frame(16'h0F0F, 32);
      run_frames(1, 32);
      check_underrun("short_underrun", 8'd0);
   endtask

   initial begin
      test_reset();
      test_single_sample();
      test_underrun();
      test_back_to_back();
      test_fill_on_lr_fall();
      test_saturation();
      test_reset_mid_shift();
      test_short_slot();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
